// File: rtl/word_split_32_pkg.sv
// Shared definitions for the word splitter.
//   state_e      : FSM state encoding (StIdle=0, StSendLo=1, StSendHi=2)
//   DefaultHalfW : default width of one output half
package word_split_32_pkg;

  localparam int unsigned DefaultHalfW = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSendLo = 2'd1,
    StSendHi = 2'd2
  } state_e;

endpackage

// File: rtl/word_split_fsm.sv
// Control FSM for the word splitter: state register, next-state and handshake logic.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   in_valid   : upstream offers a word
//   out_ready  : downstream takes the presented half
//   in_ready   : a word can be accepted this cycle
//   accept     : in_valid & in_ready, loads the word register
//   state      : current state, drives the output mux in the top
module word_split_fsm
  import word_split_32_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  input  logic   out_ready,
  output logic   in_ready,
  output logic   accept,
  output state_e state
);

  state_e state_q;

  // Idle always takes a word; SendHi takes the next one as the upper half leaves,
  // which gives one half per cycle when streaming.
  assign in_ready = (state_q == StIdle) | ((state_q == StSendHi) & out_ready);
  assign accept   = in_valid & in_ready;
  assign state    = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) state_q <= StSendLo;
        end
        StSendLo: begin
          if (out_ready) state_q <= StSendHi;
        end
        StSendHi: begin
          if (out_ready) state_q <= in_valid ? StSendLo : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/word_split_32.sv
// Splits each 2*HALF_W-bit input word into two HALF_W-bit halves, lower half first.
// Optional feature macro: WORD_SPLIT_PARITY_EN adds out_par (even parity of out_data).
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : word handshake, in_data is the offered word
//   out_valid/out_ready : half handshake, out_data is the half, out_last marks the upper half
//   out_par             : XOR of out_data (WORD_SPLIT_PARITY_EN only)
module word_split_32
  import word_split_32_pkg::*;
#(
  parameter int unsigned HALF_W = DefaultHalfW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [2*HALF_W-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [HALF_W-1:0]   out_data,
  output logic                out_last,
  input  logic                out_ready
`ifdef WORD_SPLIT_PARITY_EN
  ,
  output logic                out_par
`endif
);

  localparam int unsigned WordW = 2 * HALF_W;

  logic [WordW-1:0] word_q;
  state_e           state;
  logic             accept;

  word_split_fsm u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .accept    (accept),
    .state     (state)
  );

  // Only loads on acceptance, so the word holds through any stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
    end else if (accept) begin
      word_q <= in_data;
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    unique case (state)
      StIdle: ;
      StSendLo: begin
        out_valid = 1'b1;
        out_data  = word_q[HALF_W-1:0];
      end
      StSendHi: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = word_q[WordW-1:HALF_W];
      end
      default: ;
    endcase
  end

`ifdef WORD_SPLIT_PARITY_EN
  assign out_par = ^out_data;
`endif

endmodule

// File: doc/word_split_32.md
WORD_SPLIT_32 -- requirements
Module: word_split_32

Interface
- REQ-001 SHALL have parameter HALF_W, default 16: width of each output half; the input word width is 2*HALF_W.
- REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
- REQ-004 SHALL have port in_valid, input, 1 bit: a full word is offered.
- REQ-005 SHALL have port in_data, input, 2*HALF_W bits: the word offered.
- REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the word this cycle.
- REQ-007 SHALL have port out_valid, output, 1 bit: a half is presented.
- REQ-008 SHALL have port out_data, output, HALF_W bits: the half presented.
- REQ-009 SHALL have port out_last, output, 1 bit: the presented half is the upper half.
- REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the presented half.
- REQ-011 SHALL have port out_par, output, 1 bit: even parity of out_data; present only when PARITY_EN is defined.

Function
- REQ-012 SHALL implement a three-state FSM: IDLE, SEND_LO, SEND_HI.
- REQ-013 SHALL accept a word on the rising edge where in_valid & in_ready, capturing in_data into an internal 2*HALF_W word register.
- REQ-014 SHALL drive in_ready = (state==IDLE) | (state==SEND_HI & out_ready), purely combinational from state and out_ready.
- REQ-015 SHALL move to SEND_LO on acceptance; out_valid SHALL rise in the cycle after acceptance (1-cycle latency), with out_data = word[HALF_W-1:0] and out_last=0.
- REQ-016 SHALL move from SEND_LO to SEND_HI on out_valid & out_ready, presenting word[2*HALF_W-1:HALF_W] with out_last=1.
- REQ-017 SHALL leave SEND_HI on out_ready: go to SEND_LO with the newly captured word if in_valid is high that cycle, else to IDLE.
- REQ-018 SHALL sustain back-to-back throughput of one half per cycle, i.e. one word every two cycles, with no bubble when in_valid and out_ready are held high.
- REQ-019 SHALL hold out_data, out_last and out_valid stable while out_valid & ~out_ready (stall); the word register SHALL NOT change during a stall.
- REQ-020 SHALL drive out_valid=0 exactly when state==IDLE; out_data in IDLE SHALL be 0.
- REQ-021 SHALL ignore in_data when in_valid is low or in_ready is low.

Reset
- REQ-022 SHALL, on a rising clk with rst_n=0, force state=IDLE and the word register to 0; out_valid, out_last and out_data are then 0, and in_ready is 1 from the first cycle after reset deasserts.
- REQ-023 SHALL discard a partially sent word on mid-operation reset, with no half emitted afterwards.
- REQ-024 SHALL give reset priority over a simultaneous input or output handshake.

Configuration
- REQ-025 SHALL compile in port out_par and its logic only when macro WORD_SPLIT_PARITY_EN is defined; out_par = XOR-reduction of out_data, so it is 0 in IDLE and after reset.
- REQ-026 SHALL omit out_par entirely without WORD_SPLIT_PARITY_EN, with all other behaviour identical.

Structure
- REQ-027 SHALL place in a shared package: the FSM state enumeration (2-bit encoding IDLE=0, SEND_LO=1, SEND_HI=2) and the default half width constant 16.
- REQ-028 SHALL instantiate one sub-module, word_split_fsm, holding the state register and the next-state and handshake logic; the word register and output mux stay in the top module.

Verification
- REQ-029 Single word: in_data=0xDEADBEEF accepted at cycle 0, out_ready=1 -> cycle 1 out_data=0xBEEF, out_last=0; cycle 2 out_data=0xDEAD, out_last=1; cycle 3 out_valid=0.
- REQ-030 Stall: out_ready=0 for 3 cycles during SEND_LO -> out_data holds 0xBEEF and in_ready=0 throughout; upper half follows the first cycle after out_ready=1.
- REQ-031 Streaming: words 0x11112222, 0x33334444 with in_valid and out_ready held 1 -> out_data sequence 0x2222, 0x1111, 0x4444, 0x3333 on 4 consecutive cycles.
- REQ-032 Reset mid-word: rst_n=0 for one cycle while in SEND_HI -> next cycle out_valid=0, in_ready=1, and 0xDEAD is never emitted.
- REQ-033 Parity (WORD_SPLIT_PARITY_EN defined): halves 0x0001 then 0x0003 -> out_par=1 then 0.
- REQ-034 Backpressure in SEND_HI: in_valid=1, out_ready=0 -> in_ready=0 and the offered word is not captured until out_ready=1.
